// File: rtl/program_sequencer.sv
// Fetch/execute controller for the 8-bit accumulator core: owns the PC and IR,
// issues one exec_en per instruction, and handles JMP/JC/HALT plus run/step control.
module program_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   carry_flag,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   exec_en,
  output logic                   halted,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALTED  = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   cont_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  pc_d;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic [COUNT_WIDTH-1:0] retired_d;
  logic [3:0]             opcode;
  logic [ADDR_WIDTH-1:0]  target;
  logic                   is_ctrl;

  assign opcode  = ir_q[INSTR_WIDTH-1 -: 4];
  assign target  = ir_q[ADDR_WIDTH-1:0];
  assign is_ctrl = (opcode == OP_JC) || (opcode == OP_JMP) || (opcode == OP_HALT);

  // Next PC for the instruction currently in EXECUTE
  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(1);
    case (opcode)
      OP_JMP:  pc_d = target;
      OP_JC:   if (carry_flag) pc_d = target;
      OP_HALT: pc_d = pc_q;
      default: ;
    endcase
  end

  // Retired count sticks at all-ones
  assign retired_d = (retired_q == '1) ? retired_q : retired_q + COUNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cont_q    <= 1'b0;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            cont_q  <= 1'b1;
          end else if (step) begin
            state_q <= S_FETCH;
            cont_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_q    <= instruction;
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          pc_q      <= pc_d;
          retired_q <= retired_d;
          if (opcode == OP_HALT)   state_q <= S_HALTED;
          else if (cont_q && run)  state_q <= S_FETCH;
          else                     state_q <= S_IDLE;
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign retired = retired_q;
  assign exec_en = (state_q == S_EXECUTE) && !is_ctrl;
  assign busy    = (state_q == S_FETCH) || (state_q == S_EXECUTE);
  assign halted  = (state_q == S_HALTED);

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: an instruction-level model predicts each
// executed instruction and the quiescent state; a monitor compares what the DUT shows.
module tb_program_sequencer;

  localparam int unsigned AW = 5;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 5;
  localparam int DEPTH = 1 << AW;
  localparam int RMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          carry_flag = 1'b0;
  logic [IW-1:0] instruction;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  logic          exec_en;
  logic          halted;
  logic          busy;
  logic [CW-1:0] retired;

  logic [IW-1:0] mem [DEPTH];
  assign instruction = mem[pc];

  always #5 clk = ~clk;

  program_sequencer #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .instruction(instruction),
    .carry_flag (carry_flag),
    .pc         (pc),
    .ir         (ir),
    .exec_en    (exec_en),
    .halted     (halted),
    .busy       (busy),
    .retired    (retired)
  );

  typedef struct {
    int pc; int ir; int en; int pc_after; int retired; int halted;
  } exec_t;
  typedef struct {
    int pc; int retired; int halted;
  } idle_t;

  exec_t exp_q[$];
  idle_t idle_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    done = 1'b0;

  // Architectural model state
  int m_pc = 0;
  int m_retired = 0;
  bit m_halted = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [IW-1:0] rand_instr(bit datapath_only);
    int v;
    logic [3:0] op;
    v = datapath_only ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 19));
    if (v < 13)      op = 4'(v);
    else if (v < 16) op = 4'hD;
    else if (v < 19) op = 4'hE;
    else             op = 4'hF;
    return {op, 12'($urandom)};
  endfunction

  function automatic void fill_datapath();
    for (int i = 0; i < DEPTH; i++) mem[i] = rand_instr(1'b1);
  endfunction

  // Executes the instruction at m_pc in the model and records what the DUT must show
  function automatic void model_step(bit c);
    exec_t e;
    logic [IW-1:0] ins;
    int op;
    int tgt;
    ins = mem[m_pc];
    op  = int'(ins[IW-1 -: 4]);
    tgt = int'(ins[AW-1:0]);
    e.pc = m_pc;
    e.ir = int'(ins);
    e.en = (op < 13) ? 1 : 0;
    if (op == 14)      m_pc = tgt;
    else if (op == 13) m_pc = c ? tgt : (m_pc + 1) % DEPTH;
    else if (op == 15) m_halted = 1'b1;
    else               m_pc = (m_pc + 1) % DEPTH;
    if (m_retired < RMAX) m_retired++;
    e.pc_after = m_pc;
    e.retired  = m_retired;
    e.halted   = int'(m_halted);
    exp_q.push_back(e);
  endfunction

  task automatic push_idle();
    idle_t r;
    r.pc = m_pc;
    r.retired = m_retired;
    r.halted = int'(m_halted);
    idle_q.push_back(r);
  endtask

  // Bounded wait for the DUT to leave FETCH/EXECUTE, then request a quiescent check
  task automatic settle();
    for (int k = 0; k < 16 && busy; k++) @(negedge clk);
    push_idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_retired = 0; m_halted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_idle();
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // run held for r edges executes 1+(r-1)/2 instructions (fewer if HALT is hit)
  task automatic burst_run(int r, bit c, int smode);
    int n;
    n = 1 + (r - 1) / 2;
    carry_flag = c;
    for (int i = 0; i < n && !m_halted; i++) model_step(c);
    for (int i = 0; i < r; i++) begin
      run  = 1'b1;
      step = (smode == 1 && i == 0) || (smode == 2 && $urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    run = 1'b0; step = 1'b0;
    settle();
  endtask

  // step held for up to 3 edges still yields one instruction
  task automatic burst_step(int len, bit c);
    carry_flag = c;
    if (!m_halted) model_step(c);
    for (int i = 0; i < len; i++) begin
      step = 1'b1;
      @(negedge clk);
    end
    step = 1'b0;
    settle();
  endtask

  initial begin : stimulus
    fill_datapath();
    do_reset();

    // Straight-line program ending in HALT, then poke the halted core
    mem[4] = 16'hF000;
    burst_run(20, 1'b0, 0);
    burst_run(6, 1'b0, 2);
    burst_step(1, 1'b0);

    // Single stepping
    do_reset();
    fill_datapath();
    burst_step(1, 1'b0);
    burst_step(3, 1'b0);

    // JMP, then JC not taken and taken
    do_reset();
    fill_datapath();
    mem[2] = 16'hE007;
    mem[7] = 16'hD000;
    mem[8] = 16'hD000;
    burst_run(5, 1'b0, 0);
    burst_step(1, 1'b0);
    burst_step(2, 1'b1);

    // PC wrap with retired saturation, and run dropped during FETCH
    do_reset();
    fill_datapath();
    burst_run(69, 1'b0, 0);
    burst_run(1, 1'b0, 0);
    burst_run(2, 1'b0, 0);

    // Reset while EXECUTE is in progress at pc=9
    do_reset();
    fill_datapath();
    burst_run(17, 1'b0, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_retired = 0; m_halted = 1'b0;
    push_idle();
    @(negedge clk);
    @(negedge clk);

    // run and step together select continuous mode
    burst_run(3, 1'b0, 1);

    // Randomized programs and control
    do_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = rand_instr(1'b0);
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) do_reset();
      for (int k = 0; k < 4; k++) mem[AW'($urandom_range(0, DEPTH - 1))] = rand_instr(1'b0);
      if ($urandom_range(0, 2) == 0)
        burst_step(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      else
        burst_run(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 2);
    end
    done = 1'b1;
  end

  initial begin : monitor
    bit    phase;
    bit    pend;
    bit    rst_e;
    int    s_pc;
    int    s_ir;
    int    s_en;
    exec_t e;
    idle_t r;
    phase = 1'b0;
    pend  = 1'b0;
    while (!done) begin
      @(posedge clk);
      rst_e = rst;
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (rst_e) begin
          chk("reset_mid_exec_pc", int'(pc), 0);
          chk("reset_mid_exec_ir", int'(ir), 0);
          chk("reset_mid_exec_retired", int'(retired), 0);
          chk("reset_mid_exec_busy", int'(busy), 0);
          chk("reset_mid_exec_halted", int'(halted), 0);
        end else begin
          chk("exec_queue_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("exec_pc", s_pc, e.pc);
            chk("exec_ir", s_ir, e.ir);
            chk("exec_en", s_en, e.en);
            chk("pc_after", int'(pc), e.pc_after);
            chk("retired_after", int'(retired), e.retired);
            chk("halted_after", int'(halted), e.halted);
          end
        end
      end
      // Busy cycles alternate FETCH then EXECUTE
      if (busy && phase) begin
        s_pc  = int'(pc);
        s_ir  = int'(ir);
        s_en  = int'(exec_en);
        pend  = 1'b1;
        phase = 1'b0;
      end else begin
        chk("exec_en_outside_execute", int'(exec_en), 0);
        phase = busy;
      end
      if (idle_q.size() > 0) begin
        r = idle_q.pop_front();
        chk("idle_busy", int'(busy), 0);
        chk("idle_pc", int'(pc), r.pc);
        chk("idle_retired", int'(retired), r.retired);
        chk("idle_halted", int'(halted), r.halted);
      end
    end
    chk("exec_queue_drained", exp_q.size(), 0);
    chk("idle_queue_drained", idle_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Multi-cycle fetch/execute controller for the 8-bit accumulator core. It replaces the free-running program counter: it owns the PC, latches each instruction into an instruction register, and issues exactly one `exec_en` pulse per instruction. Downstream, `RF_we`, `MEM_we` and `A_we` are ANDed with `exec_en`. The block also handles the control-flow opcodes (JMP, JC, HALT) and provides run/single-step control for bring-up.

## Interface

Parameters:
- `ADDR_WIDTH`, default 5: PC width. The program memory depth is 2^ADDR_WIDTH.
- `INSTR_WIDTH`, default 16: instruction width. Must be at least 4 + ADDR_WIDTH.
- `COUNT_WIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `run`  in  1: level. While high, the block executes instructions back to back.
- `step`  in  1: single-cycle pulse. Executes one instruction when idle and `run` is low.
- `instruction`  in  INSTR_WIDTH: combinational output of program memory at address `pc`.
- `carry_flag`  in  1: registered carry from the carry flip-flop.
- `pc`  out  ADDR_WIDTH: instruction address driven to program memory.
- `ir`  out  INSTR_WIDTH: latched instruction, feeding the instruction decoder.
- `exec_en`  out  1: datapath write enable for the current instruction.
- `halted`  out  1: high once a HALT instruction has executed.
- `busy`  out  1: high in FETCH or EXECUTE.
- `retired`  out  COUNT_WIDTH: number of instructions executed since reset. Saturates at all-ones.

## Operation

Opcode field is `ir[INSTR_WIDTH-1 -: 4]`. Target field is `ir[ADDR_WIDTH-1:0]`.
- 4'hE, JMP: next PC = target.
- 4'hD, JC: next PC = target if `carry_flag`=1, else PC+1.
- 4'hF, HALT: PC is not advanced; go to HALTED.
- Any other opcode is a datapath instruction: next PC = PC+1.

PC+1 is modulo 2^ADDR_WIDTH. With the default width, 31 wraps to 0.

State machine, four states: IDLE, FETCH, EXECUTE, HALTED.
- **IDLE**
  - If `run`=1, go to FETCH in continuous mode.
  - Else if `step`=1, go to FETCH in step mode.
  - Else stay in IDLE.
  - If `run` and `step` are both high, `run` wins.
- **FETCH**
  - `ir` <= `instruction`.
  - Go to EXECUTE.
- **EXECUTE**
  - `exec_en`=1 unless the opcode is JMP, JC or HALT. Control-flow instructions never write the datapath.
  - Update PC according to the opcode rules above.
  - `retired` increments for every opcode, including HALT.
  - Next state:
    - HALT: go to HALTED.
    - Step mode: go to IDLE.
    - Continuous mode with `run`=1: go to FETCH.
    - Continuous mode with `run`=0: go to IDLE.
- **HALTED**
  - `halted`=1.
  - `run` and `step` are ignored.
  - Exits only on `rst`.

Mode capture and ignored inputs:
- The mode (continuous or step) is latched on the IDLE->FETCH transition.
- `step` is ignored outside IDLE.
- Deasserting `run` during FETCH or EXECUTE lets the current instruction complete, then returns to IDLE. Instructions are never aborted.

## Timing

- Reset values: state IDLE, `pc`=0, `ir`=0, `exec_en`=0, `halted`=0, `busy`=0, `retired`=0, mode = step.
- `exec_en`, `busy` and `halted` are decoded combinationally from the state and `ir`.
- Each instruction takes 2 cycles, FETCH then EXECUTE. Continuous throughput is one instruction every 2 cycles.
- Latency from `run` or `step` sampled high in IDLE to the `exec_en` pulse: 2 edges. `exec_en` is high during the second cycle after the sampling edge.
- `pc` and `retired` update on the edge that ends EXECUTE. The datapath commits on that same edge, using the old `pc`/`ir`.
- JC samples `carry_flag` during the EXECUTE cycle. This is the carry left by the previous executed instruction.
- Reset mid-operation: `rst` high at an edge forces all reset values on that edge, overriding every other transition. An `exec_en` that was high in the cycle before that edge still commits on that edge. No partial state survives.
- `retired` at all-ones stays at all-ones. It does not wrap.

## Test plan

- **Reset and idle.** Assert `rst` for 2 cycles, then hold `run`=0 and `step`=0 for 10 cycles -> `pc`=0, `exec_en`=0, `busy`=0, `retired`=0 throughout.
- **Continuous run.** Memory holds datapath opcodes at 0-3 and HALT at 4; `run`=1 -> `exec_en` pulses on cycles 2, 4, 6 and 8. Then `halted`=1, `pc`=4, `retired`=5, and `exec_en` stays 0 while in HALTED.
- **Single step.**
  - `run`=0 with one `step` pulse -> exactly one `exec_en` pulse, then `pc`=1 and state IDLE.
  - A second `step` asserted during the EXECUTE cycle is ignored, so `pc` stays 1.
- **Jumps.**
  - JMP 7 at address 2 -> `pc` goes 2->7 with no `exec_en` pulse.
  - JC 0 with `carry_flag`=0 -> `pc`+1.
  - JC 0 with `carry_flag`=1 -> `pc`=0.
- **Wrap and run drop.**
  - With no control-flow opcodes, `pc` goes 31->0 and execution continues.
  - Dropping `run` during FETCH -> that instruction still executes once, then IDLE.
- **Reset mid-EXECUTE and precedence.**
  - `rst` asserted during EXECUTE at `pc`=9 -> on the next edge `pc`=0, `ir`=0, state IDLE, and `retired` is not incremented.
  - `run` and `step` asserted together in IDLE -> continuous mode.
